// File: rtl/frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sched_pkg
// Description : Shared types and constants for the frame bank scheduler.
//               Defines the scheduler states, the bank index type, the bank
//               count, the default detection configuration and the helper
//               that picks the free bank.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

  typedef logic [1:0] bank_t;

  localparam int unsigned NUM_BANKS       = 3;
  localparam logic [7:0]  C_DEF_THRESHOLD = 8'd80;
  localparam logic [9:0]  C_DEF_MIN_DIST  = 10'd30;

  // The three bank indices sum to 3, so the bank that is neither being
  // written nor read is 3 - w - r. Operands never exceed 3 in total, so the
  // 2-bit arithmetic cannot wrap.
  function automatic bank_t free_bank(input bank_t w, input bank_t r);
    return bank_t'(2'(NUM_BANKS) - w - r);
  endfunction

endpackage : frame_sched_pkg
`default_nettype wire

// File: rtl/cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : cfg_shadow
// Description : Shadow register for the run-time detection configuration.
//               Accepts one offer over a valid/ready handshake, holds it
//               pending and applies it at the next frame start.
// Ports       : clk, rst              clock, synchronous active-high reset
//               i_fs                  frame-start strobe
//               i_cfg_valid/o_cfg_ready  offer handshake
//               i_cfg_threshold/i_cfg_min_dist  offered values
//               o_diff_threshold/o_min_dist     applied values
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_shadow #(
  parameter logic [7:0] DEF_THRESHOLD = 8'd80,
  parameter logic [9:0] DEF_MIN_DIST  = 10'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fs,
  input  logic       i_cfg_valid,
  input  logic [7:0] i_cfg_threshold,
  input  logic [9:0] i_cfg_min_dist,
  output logic       o_cfg_ready,
  output logic [7:0] o_diff_threshold,
  output logic [9:0] o_min_dist
);

  logic       r_ready;
  logic       r_pending;
  logic       r_reopen;   // apply happened last cycle; re-open the port now
  logic [7:0] r_pend_thr;
  logic [9:0] r_pend_md;
  logic [7:0] r_thr;
  logic [9:0] r_md;

  logic w_take;
  logic w_apply;

  assign w_take  = i_cfg_valid & r_ready;
  assign w_apply = i_fs & r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b1;
      r_pending  <= 1'b0;
      r_reopen   <= 1'b0;
      r_pend_thr <= '0;
      r_pend_md  <= '0;
      r_thr      <= DEF_THRESHOLD;
      r_md       <= DEF_MIN_DIST;
    end else begin
      r_reopen <= w_apply;

      if (w_apply) begin
        r_thr <= r_pend_thr;
        r_md  <= r_pend_md;
      end

      // A take needs ready, which implies nothing is pending, so take and
      // apply never compete for the pending register.
      if (w_take) begin
        r_pending  <= 1'b1;
        r_pend_thr <= i_cfg_threshold;
        r_pend_md  <= i_cfg_min_dist;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end

      if (w_take) begin
        r_ready <= 1'b0;
      end else if (r_reopen) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign o_cfg_ready      = r_ready;
  assign o_diff_threshold = r_thr;
  assign o_min_dist       = r_md;

endmodule : cfg_shadow
`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank_scheduler
// Description : Frame-differencing front-end sequencer. Rotates three SDRAM
//               frame banks (write bank for the incoming frame, read bank
//               replaying the previous one) at every frame start, drops
//               frames while either memory engine is still busy, and
//               shadows the detection configuration to frame boundaries.
// Ports       : sys_clk, sys_rst           clock, sync active-high reset
//               per_frame_vsync            camera vsync (rising edge = frame)
//               wr_done, rd_done           engine completion pulses
//               wr_start, rd_start         engine launch pulses
//               wr_bank/rd_bank, wr_base/rd_base  bank indices and bases
//               diff_en                    difference result valid
//               cfg_*                      config handshake and values
//               diff_threshold, min_dist   applied configuration
//               frame_cnt, drop_cnt        accepted / dropped frame counts
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 24,
  parameter logic [ADDR_W-1:0] BANK_STRIDE   = 24'h04B000,
  parameter logic [7:0]        DEF_THRESHOLD = C_DEF_THRESHOLD,
  parameter logic [9:0]        DEF_MIN_DIST  = C_DEF_MIN_DIST
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              per_frame_vsync,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              wr_start,
  output logic              rd_start,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              diff_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_threshold,
  input  logic [9:0]        cfg_min_dist,
  output logic [7:0]        diff_threshold,
  output logic [9:0]        min_dist,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam bank_t             c_RST_WR_BANK = 2'd0;
  localparam bank_t             c_RST_RD_BANK = 2'd2;
  localparam logic [ADDR_W-1:0] c_RST_RD_BASE = BANK_STRIDE * ADDR_W'(c_RST_RD_BANK);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic              r_vsync_d;
  logic              r_wr_busy;
  logic              r_rd_busy;
  logic              r_wr_start;
  logic              r_rd_start;
  bank_t             r_wr_bank;
  bank_t             r_rd_bank;
  logic [ADDR_W-1:0] r_wr_base;
  logic [ADDR_W-1:0] r_rd_base;
  logic              r_diff_en;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;

  logic  w_fs;
  logic  w_wr_idle;
  logic  w_rd_idle;
  logic  w_launch_wr;
  logic  w_launch_rd;
  logic  w_drop;
  bank_t w_wr_bank_next;

  assign w_fs = per_frame_vsync & ~r_vsync_d;

  // A done pulse in the frame-start cycle already counts the engine as idle.
  assign w_wr_idle = ~r_wr_busy | wr_done;
  assign w_rd_idle = ~r_rd_busy | rd_done;

  assign w_wr_bank_next = free_bank(r_wr_bank, r_rd_bank);

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch_wr  = 1'b0;
    w_launch_rd  = 1'b0;
    w_drop       = 1'b0;
    if (w_fs) begin
      case (r_state)
        ST_IDLE: begin
          // First frame: nothing to replay yet, only capture.
          w_launch_wr  = 1'b1;
          w_state_next = ST_PRIME;
        end
        ST_PRIME, ST_RUN: begin
          if (w_wr_idle && w_rd_idle) begin
            w_launch_wr  = 1'b1;
            w_launch_rd  = 1'b1;
            w_state_next = ST_RUN;
          end else begin
            w_drop = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bank rotation, engine tracking, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_vsync_d   <= 1'b0;
      r_wr_busy   <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_wr_start  <= 1'b0;
      r_rd_start  <= 1'b0;
      r_wr_bank   <= c_RST_WR_BANK;
      r_rd_bank   <= c_RST_RD_BANK;
      r_wr_base   <= '0;
      r_rd_base   <= c_RST_RD_BASE;
      r_diff_en   <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_vsync_d  <= per_frame_vsync;
      r_wr_start <= w_launch_wr;
      r_rd_start <= w_launch_rd;

      if (w_launch_wr) begin
        r_wr_busy <= 1'b1;
      end else if (wr_done) begin
        r_wr_busy <= 1'b0;
      end

      if (w_launch_rd) begin
        r_rd_busy <= 1'b1;
      end else if (rd_done) begin
        r_rd_busy <= 1'b0;
      end

      if (w_launch_rd) begin
        // The frame just written becomes the replay source; write into the
        // bank that neither engine was using.
        r_rd_bank <= r_wr_bank;
        r_rd_base <= r_wr_base;
        r_wr_bank <= w_wr_bank_next;
        r_wr_base <= BANK_STRIDE * ADDR_W'(w_wr_bank_next);
      end else if (w_launch_wr) begin
        r_wr_bank <= c_RST_WR_BANK;
        r_wr_base <= '0;
      end

      // Only an accepted frame with a replayed predecessor yields a valid
      // difference; the first frame and dropped frames do not.
      if (w_fs) begin
        r_diff_en <= w_launch_rd;
      end

      if (w_launch_wr) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Configuration shadow
  // --------------------------------------------------------------------------
  cfg_shadow #(
    .DEF_THRESHOLD (DEF_THRESHOLD),
    .DEF_MIN_DIST  (DEF_MIN_DIST)
  ) u_cfg_shadow (
    .clk              (sys_clk),
    .rst              (sys_rst),
    .i_fs             (w_fs),
    .i_cfg_valid      (cfg_valid),
    .i_cfg_threshold  (cfg_threshold),
    .i_cfg_min_dist   (cfg_min_dist),
    .o_cfg_ready      (cfg_ready),
    .o_diff_threshold (diff_threshold),
    .o_min_dist       (min_dist)
  );

  assign wr_start  = r_wr_start;
  assign rd_start  = r_rd_start;
  assign wr_bank   = r_wr_bank;
  assign rd_bank   = r_rd_bank;
  assign wr_base   = r_wr_base;
  assign rd_base   = r_rd_base;
  assign diff_en   = r_diff_en;
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule : frame_bank_scheduler
`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_bank_scheduler
// Description : Self-checking bench for frame_bank_scheduler. A behavioural
//               model tracks the expected outputs each cycle; directed
//               scenarios add fixed expectations, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_bank_scheduler;

  localparam logic [23:0] STRIDE = 24'h04B000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        wr_done = 1'b0;
  logic        rd_done = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_threshold = 8'd0;
  logic [9:0]  cfg_min_dist = 10'd0;
  logic        wr_start, rd_start, diff_en, cfg_ready;
  logic [1:0]  wr_bank, rd_bank;
  logic [23:0] wr_base, rd_base;
  logic [7:0]  diff_threshold;
  logic [9:0]  min_dist;
  logic [15:0] frame_cnt, drop_cnt;

  frame_bank_scheduler dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .per_frame_vsync (per_frame_vsync),
    .wr_done         (wr_done),
    .rd_done         (rd_done),
    .wr_start        (wr_start),
    .rd_start        (rd_start),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .wr_base         (wr_base),
    .rd_base         (rd_base),
    .diff_en         (diff_en),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_threshold   (cfg_threshold),
    .cfg_min_dist    (cfg_min_dist),
    .diff_threshold  (diff_threshold),
    .min_dist        (min_dist),
    .frame_cnt       (frame_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int preload_req  = 0;
  int preload_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: expected outputs after each clock edge
  // --------------------------------------------------------------------------
  bit          m_started;   // at least one frame has been captured
  bit          m_vs_prev;
  bit          m_wbusy, m_rbusy;
  bit          m_wst, m_rdst, m_diff;
  logic [1:0]  m_w, m_r;
  bit          m_ready, m_pend, m_reopen;
  logic [7:0]  m_thr, m_pthr;
  logic [9:0]  m_md, m_pmd;
  logic [15:0] m_fc, m_dc;

  always @(posedge sys_clk) begin
    bit         fs, wfree, rfree, take, apply;
    logic [1:0] old_w;
    if (sys_rst) begin
      m_started = 0; m_vs_prev = 0; m_wbusy = 0; m_rbusy = 0;
      m_wst = 0; m_rdst = 0; m_diff = 0; m_w = 2'd0; m_r = 2'd2;
      m_ready = 1; m_pend = 0; m_reopen = 0;
      m_thr = 8'd80; m_md = 10'd30; m_pthr = 8'd0; m_pmd = 10'd0;
      m_fc = 16'd0; m_dc = 16'd0;
    end else begin
      fs = per_frame_vsync && !m_vs_prev;
      m_vs_prev = per_frame_vsync;
      if (preload_req != preload_seen) begin
        m_dc = 16'hFFFE;
        preload_seen = preload_req;
      end
      wfree = !m_wbusy || wr_done;
      rfree = !m_rbusy || rd_done;
      m_wst = 0; m_rdst = 0;

      take  = cfg_valid && m_ready;
      apply = fs && m_pend;
      if (apply) begin m_thr = m_pthr; m_md = m_pmd; m_pend = 0; end
      if (take) begin m_pend = 1; m_pthr = cfg_threshold; m_pmd = cfg_min_dist; m_ready = 0; end
      else if (m_reopen) m_ready = 1;
      m_reopen = apply;

      if (fs) begin
        if (!m_started) begin
          m_started = 1; m_wst = 1; m_w = 2'd0; m_diff = 0; m_fc++;
          wfree = 0;
        end else if (!wfree || !rfree) begin
          m_diff = 0;
          if (m_dc != 16'hFFFF) m_dc++;
        end else begin
          old_w = m_w;
          m_w = 2'(3 - int'(m_w) - int'(m_r));
          m_r = old_w;
          m_wst = 1; m_rdst = 1; m_diff = 1; m_fc++;
          wfree = 0; rfree = 0;
        end
      end
      m_wbusy = !wfree;
      m_rbusy = !rfree;
    end
  end

  task automatic compare_all();
    check("wr_start", 32'(wr_start), 32'(m_wst));
    check("rd_start", 32'(rd_start), 32'(m_rdst));
    check("wr_bank", 32'(wr_bank), 32'(m_w));
    check("rd_bank", 32'(rd_bank), 32'(m_r));
    check("wr_base", 32'(wr_base), 32'(24'(m_w) * STRIDE));
    check("rd_base", 32'(rd_base), 32'(24'(m_r) * STRIDE));
    check("diff_en", 32'(diff_en), 32'(m_diff));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("diff_threshold", 32'(diff_threshold), 32'(m_thr));
    check("min_dist", 32'(min_dist), 32'(m_md));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("drop_cnt", 32'(drop_cnt), 32'(m_dc));
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (chk_en) compare_all();
  endtask

  // After return the outputs of the frame start are visible (cycle t+1).
  task automatic vs_pulse();
    per_frame_vsync = 1'b1;
    tick();
    per_frame_vsync = 1'b0;
  endtask

  task automatic dones(input bit w, input bit r);
    wr_done = w; rd_done = r;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  task automatic chk_banks(input string tag, input logic [1:0] w, input logic [1:0] r);
    check({tag, "_wbank"}, 32'(wr_bank), 32'(w));
    check({tag, "_rbank"}, 32'(rd_bank), 32'(r));
  endtask

  initial begin
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk_en = 1'b1;
    tick();
    chk_banks("reset", 2'd0, 2'd2);
    check("reset_rd_base", 32'(rd_base), 32'h096000);
    check("reset_ready", 32'(cfg_ready), 32'd1);
    check("reset_thr", 32'(diff_threshold), 32'd80);
    sys_rst = 1'b0;
    tick();

    // Normal rotation
    vs_pulse();
    chk_banks("f1", 2'd0, 2'd2);
    check("f1_wst", 32'(wr_start), 32'd1);
    check("f1_rst", 32'(rd_start), 32'd0);
    check("f1_diff", 32'(diff_en), 32'd0);
    tick(); dones(1, 1); tick();
    vs_pulse();
    chk_banks("f2", 2'd1, 2'd0);
    check("f2_rst", 32'(rd_start), 32'd1);
    check("f2_diff", 32'(diff_en), 32'd1);
    tick();
    check("f2_wst_width", 32'(wr_start), 32'd0);
    dones(1, 1); tick();
    vs_pulse();
    chk_banks("f3", 2'd2, 2'd1);
    check("f3_diff", 32'(diff_en), 32'd1);
    check("f3_fcnt", 32'(frame_cnt), 32'd3);
    tick();

    // Writer late: frame dropped
    dones(0, 1); tick();
    vs_pulse();
    chk_banks("drop", 2'd2, 2'd1);
    check("drop_wst", 32'(wr_start), 32'd0);
    check("drop_rst", 32'(rd_start), 32'd0);
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
    check("drop_diff", 32'(diff_en), 32'd0);
    tick(); dones(1, 0); tick();
    vs_pulse();
    chk_banks("resume", 2'd0, 2'd2);
    check("resume_diff", 32'(diff_en), 32'd1);
    tick();

    // rd_done coincident with frame start
    dones(1, 0); tick();
    per_frame_vsync = 1'b1; rd_done = 1'b1;
    tick();
    per_frame_vsync = 1'b0; rd_done = 1'b0;
    check("coinc_wst", 32'(wr_start), 32'd1);
    check("coinc_rst", 32'(rd_start), 32'd1);
    chk_banks("coinc", 2'd1, 2'd0);
    tick();

    // Configuration handshake
    cfg_valid = 1'b1; cfg_threshold = 8'd40; cfg_min_dist = 10'd12;
    tick();
    cfg_threshold = 8'd99; cfg_min_dist = 10'd5;
    check("cfg_ready_low", 32'(cfg_ready), 32'd0);
    tick(); tick();
    cfg_valid = 1'b0;
    check("cfg_stall_thr", 32'(diff_threshold), 32'd80);
    check("cfg_stall_md", 32'(min_dist), 32'd30);
    dones(1, 1); tick();
    vs_pulse();
    check("cfg_thr", 32'(diff_threshold), 32'd40);
    check("cfg_md", 32'(min_dist), 32'd12);
    check("cfg_ready_t1", 32'(cfg_ready), 32'd0);
    tick();
    check("cfg_ready_t2", 32'(cfg_ready), 32'd1);

    // Drop counter saturation (engines are busy from the last frame)
    #1;
    force dut.r_drop_cnt = 16'hFFFE;
    #1;
    release dut.r_drop_cnt;
    preload_req++;
    tick();
    check("sat_pre", 32'(drop_cnt), 32'h0000FFFE);
    vs_pulse();
    check("sat_ffff", 32'(drop_cnt), 32'h0000FFFF);
    tick();
    vs_pulse();
    check("sat_hold", 32'(drop_cnt), 32'h0000FFFF);
    tick();

    // Reset in RUN with a pending configuration
    dones(1, 1);
    vs_pulse();
    tick();
    cfg_valid = 1'b1; cfg_threshold = 8'd55; cfg_min_dist = 10'd7;
    tick();
    cfg_valid = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk_banks("mid_rst", 2'd0, 2'd2);
    check("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_dcnt", 32'(drop_cnt), 32'd0);
    check("mid_rst_thr", 32'(diff_threshold), 32'd80);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    vs_pulse();
    tick(); dones(1, 1);
    vs_pulse();
    check("mid_rst_cfg_gone", 32'(diff_threshold), 32'd80);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 11) == 0) per_frame_vsync = ~per_frame_vsync;
      wr_done       = ($urandom_range(0, 4) == 0);
      rd_done       = ($urandom_range(0, 4) == 0);
      cfg_valid     = ($urandom_range(0, 5) == 0);
      cfg_threshold = 8'($urandom);
      cfg_min_dist  = 10'($urandom);
      sys_rst       = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_frame_bank_scheduler
`default_nettype wire

// File: doc/frame_bank_scheduler.md
# frame_bank_scheduler

Sequences the frame-differencing front end of the multi-target detection pipeline. It owns three SDRAM frame banks, a write bank for the incoming camera frame and a read bank that replays the previous frame as the frame-difference "B" input, and rotates them at every frame start. It drops frames when the memory engines have not finished. It also shadows the run-time detection configuration (difference threshold, minimum target distance) so that new values take effect only on a frame boundary.

## Interface
Parameters:
- `ADDR_W`, 24, width of SDRAM word addresses.
- `BANK_STRIDE`, 24'h04B000, words per bank (640×480).
- `DEF_THRESHOLD`, 8'd80, reset value of `diff_threshold`.
- `DEF_MIN_DIST`, 10'd30, reset value of `min_dist`.

Ports:
- `sys_clk`  in  1  single clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `per_frame_vsync`  in  1  camera vsync; its rising edge marks frame start.
- `wr_done`  in  1  one-cycle pulse: the writer finished storing the frame into `wr_bank`.
- `rd_done`  in  1  one-cycle pulse: the reader finished replaying `rd_bank`.
- `wr_start`  out  1  one-cycle pulse: begin writing at `wr_base`.
- `rd_start`  out  1  one-cycle pulse: begin reading from `rd_base`.
- `wr_bank`, `rd_bank`  out  2  bank indices, 0..2.
- `wr_base`, `rd_base`  out  ADDR_W  bank index × `BANK_STRIDE`.
- `diff_en`  out  1  the frame-difference result is valid for the current frame.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config accept.
- `cfg_threshold`  in  8  offered threshold value.
- `cfg_min_dist`  in  10  offered minimum-distance value.
- `diff_threshold`  out  8  applied threshold.
- `min_dist`  out  10  applied minimum distance.
- `frame_cnt`  out  16  accepted frames; wraps.
- `drop_cnt`  out  16  dropped frames; saturates at 16'hFFFF.

## Operation
Frame-start detection:
- `fs` = `per_frame_vsync` & ~`vsync_d`. `vsync_d` is the registered copy of `per_frame_vsync`.

Busy flags:
- `wr_busy` is set by `wr_start` and cleared by `wr_done`. `rd_busy` is set by `rd_start` and cleared by `rd_done`.
- A done pulse while its flag is clear is ignored.
- A done pulse in the same cycle as `fs` is applied first: the engine counts as idle for that `fs`.

FSM states: IDLE, PRIME, RUN.
- IDLE, on `fs`:
  - assert `wr_start` with `wr_bank`=0, `diff_en`=0, increment `frame_cnt`.
  - go to PRIME.
- PRIME / RUN, on `fs` with either engine busy:
  - the frame is dropped: `drop_cnt`++, no start pulses, banks unchanged, `diff_en`=0.
  - the state is unchanged.
- PRIME / RUN, on `fs` with both engines idle:
  - `rd_bank` ← old `wr_bank`.
  - `wr_bank` ← 3 − old `wr_bank` − old `rd_bank`.
  - assert `wr_start` and `rd_start`, set `diff_en`=1, increment `frame_cnt`.
  - go to RUN.
- Bank invariant: `wr_bank` ≠ `rd_bank` always. Reset values are W=0, R=2, so the first rotation gives W=1, R=0.

Config handshake:
- A transfer happens when `cfg_valid` & `cfg_ready`. It captures both fields into a pending register and drops `cfg_ready`.
- At the next `fs` (accepted or dropped, any state), the pending values are copied to `diff_threshold` and `min_dist`. `cfg_ready` returns to 1 on the following cycle.
- While a value is pending, further offers stall.

Reset values:
- IDLE; `wr_bank`=0, `rd_bank`=2; bases are 0 and 2×`BANK_STRIDE`.
- All pulses, busy flags and `diff_en` are 0; both counters are 0.
- `cfg_ready`=1; `diff_threshold`=`DEF_THRESHOLD`; `min_dist`=`DEF_MIN_DIST`; any pending config is discarded.
- Reset mid-frame abandons the in-flight transfers. Engines must be reset in the same cycle.

Arithmetic:
- Base addresses are registered alongside their bank index and truncated to `ADDR_W`.

## Timing
- `fs` is true in cycle t, the first cycle in which vsync is sampled high. All outputs updated by that frame start change in cycle t+1.
- `wr_start` and `rd_start` are high for exactly cycle t+1.
- `diff_en` holds from t+1 until the next frame start's update.
- Config applies at t+1. `cfg_ready` re-asserts at t+2.
- `vsync` held high does not retrigger `fs`. A 1-cycle-high vsync is a valid frame start.
- `fs` and `cfg_valid` in the same cycle while ready: the offer is captured and becomes pending for the *next* `fs`.

## Structure
- Package `frame_sched_pkg`:
  - `sched_state_e` enum (IDLE, PRIME, RUN).
  - `bank_t` = logic [1:0].
  - `NUM_BANKS`=3.
  - default threshold and min-dist constants.
- One sub-module: `cfg_shadow`, the pending register, valid/ready handshake and frame-boundary apply.

## Test plan
- Reset, then 3 vsync pulses with `wr_done` and `rd_done` returned between them. Expected `(wr_bank, rd_bank)` sequence: (0,2), (1,0), (2,1). `diff_en` is 0, 1, 1. `frame_cnt` is 3.
- `wr_done` withheld across the 2nd `fs`: no start pulses, banks unchanged, `drop_cnt`=1, `diff_en`=0. Return `wr_done` before the 3rd `fs`: rotation resumes.
- `rd_done` coincident with `fs` in RUN: the frame is accepted and both starts pulse at t+1.
- Offer threshold 8'd40 and min-dist 10'd12 mid-frame: `cfg_ready` falls; outputs stay 80/30 until `fs`+1, then become 40/12; `cfg_ready`=1 at `fs`+2. A second offer during pending stalls.
- Assert `sys_rst` mid-RUN with a pending config: next cycle IDLE, W=0, R=2, counters 0, threshold 80.
- Drive `drop_cnt` to 16'hFFFF, then drop another frame: it stays at 16'hFFFF.
